mdio_master: RTL

//  Clause-22 MDIO management master for the two repeater PHYs. Serialises one

---
 rtl/mdio_master.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mdio_master.sv
// Clause-22 MDIO management master: serialises one read or write command per
// request onto MDC/MDIOO/MDIOE and captures MDIOI through a 2-flop synchroniser.
module mdio_master #(
  parameter int DIV          = 2,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        CLK,
  input  logic        ARSTN,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_RD,
  input  logic [4:0]  CMD_PHYAD,
  input  logic [4:0]  CMD_REGAD,
  input  logic [15:0] CMD_WDATA,
  output logic [15:0] RDATA,
  output logic        RD_ERR,
  output logic        DONE,
  output logic        BUSY,
  output logic        MDC,
  output logic        MDIOO,
  output logic        MDIOE,
  input  logic        MDIOI,
  output logic [1:0]  STATE_DBG
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRE   = 2'd1;
  localparam logic [1:0] S_FRAME = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam int PW = $clog2(2 * DIV);
  localparam int CW = $clog2(((PREAMBLE_LEN > 32) ? PREAMBLE_LEN : 32) + 1);

  localparam logic [PW-1:0] PH_HI    = PW'(DIV);
  localparam logic [PW-1:0] PH_LAST  = PW'(2 * DIV - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(PREAMBLE_LEN - 1);
  localparam logic [CW-1:0] N_TA1    = CW'(14);
  localparam logic [CW-1:0] N_TA2    = CW'(15);
  localparam logic [CW-1:0] N_DATA   = CW'(16);
  localparam logic [CW-1:0] N_END    = CW'(32);

  logic [1:0]    state;
  logic [PW-1:0] phase;
  logic [PW-1:0] next_phase;
  logic [CW-1:0] bit_cnt;
  logic [31:0]   tx_sr;
  logic [15:0]   rx_sr;
  logic [15:0]   rdata_q;
  logic          rd_q;
  logic          err_q;
  logic          rd_err_q;
  logic          mdc_q;
  logic          mdioo_q;
  logic          mdioe_q;
  logic [1:0]    sync;
  logic          frame_drive;

  // Handshake: a command is accepted on any rising CLK edge where
  // CMD_VALID & CMD_READY; CMD_READY is high only in IDLE and never depends
  // on CMD_VALID, so a held request waits until the FSM returns to IDLE.
  assign CMD_READY   = (state == S_IDLE);
  assign BUSY        = ~CMD_READY;
  assign DONE        = (state == S_FIN);
  assign RDATA       = rdata_q;
  assign RD_ERR      = rd_err_q;
  assign MDC         = mdc_q;
  assign MDIOO       = mdioo_q;
  assign MDIOE       = mdioe_q;
  assign STATE_DBG   = state;
  assign next_phase  = (phase == PH_LAST) ? '0 : phase + 1'b1;
  // A read hands the line to the PHY from the first turnaround bit onward.
  assign frame_drive = ~rd_q | (bit_cnt < N_TA1);

  always_ff @(posedge CLK or negedge ARSTN) begin
    if (!ARSTN) begin
      state    <= S_IDLE;
      phase    <= '0;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      rdata_q  <= '0;
      rd_q     <= 1'b0;
      err_q    <= 1'b0;
      rd_err_q <= 1'b0;
      mdc_q    <= 1'b0;
      mdioo_q  <= 1'b1;
      mdioe_q  <= 1'b0;
      sync     <= 2'b11;
    end else begin
      sync <= {sync[0], MDIOI};
      case (state)
        S_IDLE: begin
          if (CMD_VALID) begin
            rd_q    <= CMD_RD;
            tx_sr   <= {2'b01, (CMD_RD ? 2'b10 : 2'b01), CMD_PHYAD, CMD_REGAD,
                        2'b10, CMD_WDATA};
            phase   <= '0;
            bit_cnt <= '0;
            state   <= (PREAMBLE_LEN == 0) ? S_FRAME : S_PRE;
          end
        end
        S_PRE: begin
          phase <= next_phase;
          if (phase == '0) begin
            mdc_q   <= 1'b0;
            mdioo_q <= 1'b1;
            mdioe_q <= 1'b1;
          end else if (phase == PH_HI) begin
            mdc_q <= 1'b1;
          end
          if (phase == PH_LAST) begin
            if (bit_cnt == PRE_LAST) begin
              bit_cnt <= '0;
              state   <= S_FRAME;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_FRAME: begin
          if ((phase == '0) && (bit_cnt == N_END)) begin
            state    <= S_FIN;
            mdc_q    <= 1'b0;
            mdioo_q  <= 1'b1;
            mdioe_q  <= 1'b0;
            rd_err_q <= rd_q & err_q;
            if (rd_q) rdata_q <= rx_sr;
          end else begin
            phase <= next_phase;
            if (phase == '0) begin
              mdc_q   <= 1'b0;
              mdioe_q <= frame_drive;
              mdioo_q <= frame_drive ? tx_sr[31] : 1'b1;
              tx_sr   <= {tx_sr[30:0], 1'b1};
            end else if (phase == PH_HI) begin
              mdc_q <= 1'b1;
              if (rd_q && (bit_cnt == N_TA2)) err_q <= sync[1];
              if (rd_q && (bit_cnt >= N_DATA)) rx_sr <= {rx_sr[14:0], sync[1]};
            end
            if (phase == PH_LAST) bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
